// File: rtl/sum_acc_pkg.sv
// Shared types and width helper for the burst sum accumulator.
package sum_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } sum_acc_state_e;

   // Sum of cnt samples of (dw+1) bits can never exceed this width.
   function automatic int acc_width(input int dw, input int cnt);
      return dw + 1 + $clog2(cnt + 1);
   endfunction

endpackage

// File: rtl/sum_acc_fsm.sv
// Burst control: owns state and sample count, issues load/add/clear/close strobes.
// Input is stalled (o_in_ready=0) in HOLD and while reset is asserted.
module sum_acc_fsm
   import sum_acc_pkg::*;
#(
   parameter int COUNT = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_in_valid,
   input  logic                        i_flush,
   input  logic                        i_out_ready,
   output logic                        o_in_ready,
   output logic                        o_out_valid,
   output logic                        o_load,
   output logic                        o_add,
   output logic                        o_clear,
   output logic                        o_close
`ifdef SUM_ACC_CNT_EN
   ,
   output logic [$clog2(COUNT+1)-1:0]  o_out_cnt
`endif
);

   localparam int CW = $clog2(COUNT + 1);

   sum_acc_state_e r_state;
   sum_acc_state_e w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  w_cnt_inc;
   logic           w_accept;
   logic           w_hit;

   assign o_in_ready  = ~i_rst & (r_state != HOLD);
   assign w_accept    = i_in_valid & o_in_ready;
   assign o_load      = w_accept & (r_state == IDLE);
   assign o_add       = w_accept & (r_state == ACCUM);
   assign o_clear     = (r_state == HOLD) & i_out_ready;
   assign o_out_valid = (r_state == HOLD);

   // cnt is 0 in IDLE, so the same increment test covers the first sample.
   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_hit     = (w_cnt_inc == CW'(COUNT));
   assign o_close   = ((o_load | o_add) & (w_hit | i_flush))
                    | ((r_state == ACCUM) & i_flush);

`ifdef SUM_ACC_CNT_EN
   assign o_out_cnt = o_out_valid ? r_cnt : '0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (o_load)  w_state_nxt = o_close ? HOLD : ACCUM;
         ACCUM:   if (o_close) w_state_nxt = HOLD;
         HOLD:    if (o_clear) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (o_load)
            r_cnt <= CW'(1);
         else if (o_add)
            r_cnt <= w_cnt_inc;
         else if (o_clear)
            r_cnt <= '0;
      end
   end

endmodule

// File: rtl/sum_accumulator.sv
// Sums COUNT adder samples per burst (or fewer on flush); total is valid the cycle after the closing accept.
// Input stalls while a total is held; SUM_ACC_CNT_EN adds the o_out_cnt sample-count port.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int COUNT      = 4,
   localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, COUNT)
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_in_valid,
   output logic                        o_in_ready,
   input  logic [DATA_WIDTH:0]         i_in_sum,
   input  logic                        i_flush,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic [ACC_WIDTH-1:0]        o_out_acc
`ifdef SUM_ACC_CNT_EN
   ,
   output logic [$clog2(COUNT+1)-1:0]  o_out_cnt
`endif
);

   logic                 w_load;
   logic                 w_add;
   logic                 w_clear;
   logic                 w_close;
   logic [ACC_WIDTH-1:0] w_sum_ext;
   logic [ACC_WIDTH-1:0] w_acc_d;
   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] r_out_acc;

   sum_acc_fsm #(
      .COUNT       (COUNT)
   ) u_fsm (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_in_valid  (i_in_valid),
      .i_flush     (i_flush),
      .i_out_ready (i_out_ready),
      .o_in_ready  (o_in_ready),
      .o_out_valid (o_out_valid),
      .o_load      (w_load),
      .o_add       (w_add),
      .o_clear     (w_clear),
      .o_close     (w_close)
`ifdef SUM_ACC_CNT_EN
      ,
      .o_out_cnt   (o_out_cnt)
`endif
   );

   assign w_sum_ext = ACC_WIDTH'(i_in_sum);

   always_comb begin
      w_acc_d = r_acc;
      if (w_load)
         w_acc_d = w_sum_ext;
      else if (w_add)
         w_acc_d = r_acc + w_sum_ext;
      else if (w_clear)
         w_acc_d = '0;
   end

   // Output copy captures the closing sum so it is stable for all of HOLD.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc     <= '0;
         r_out_acc <= '0;
      end else begin
         r_acc <= w_acc_d;
         if (w_close)
            r_out_acc <= w_acc_d;
         else if (w_clear)
            r_out_acc <= '0;
      end
   end

   assign o_out_acc = r_out_acc;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: COUNT=4 instance for burst/flush/backpressure/reset, COUNT=1 instance for throughput.
module tb_sum_accumulator;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
   logic [8:0]  a_in_sum;
   logic [11:0] a_out_acc;
   logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [8:0]  b_in_sum;
   logic [9:0]  b_out_acc;
`ifdef SUM_ACC_CNT_EN
   logic [2:0]  a_out_cnt;
   logic [0:0]  b_out_cnt;
`endif

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sum_accumulator #(.DATA_WIDTH(8), .COUNT(4)) u_dut_a (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (a_in_valid),
      .o_in_ready  (a_in_ready),
      .i_in_sum    (a_in_sum),
      .i_flush     (a_flush),
      .o_out_valid (a_out_valid),
      .i_out_ready (a_out_ready),
      .o_out_acc   (a_out_acc)
`ifdef SUM_ACC_CNT_EN
      ,
      .o_out_cnt   (a_out_cnt)
`endif
   );

   sum_accumulator #(.DATA_WIDTH(8), .COUNT(1)) u_dut_b (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (b_in_valid),
      .o_in_ready  (b_in_ready),
      .i_in_sum    (b_in_sum),
      .i_flush     (b_flush),
      .o_out_valid (b_out_valid),
      .i_out_ready (b_out_ready),
      .o_out_acc   (b_out_acc)
`ifdef SUM_ACC_CNT_EN
      ,
      .o_out_cnt   (b_out_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [8:0] v, input logic f);
      a_in_valid = 1'b1;
      a_in_sum   = v;
      a_flush    = f;
      step();
      a_in_valid = 1'b0;
      a_flush    = 1'b0;
   endtask

   task automatic deliver_a();
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      logic [31:0] exp_sum;

      rst = 1'b1;
      a_in_valid = 0; a_in_sum = 0; a_flush = 0; a_out_ready = 0;
      b_in_valid = 0; b_in_sum = 0; b_flush = 0; b_out_ready = 0;
      #2;
      chk("rst_in_ready",  32'(a_in_ready), 0);
      chk("rst_out_valid", 32'(a_out_valid), 0);
      chk("rst_out_acc",   32'(a_out_acc), 0);
      chk("rst_b_ready",   32'(b_in_ready), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rel_in_ready", 32'(a_in_ready), 1);

      // Max values, back-to-back
      a_in_valid = 1'b1;
      a_in_sum   = 9'd510;
      repeat (3) step();
      chk("max_not_yet", 32'(a_out_valid), 0);
      step();
      a_in_valid = 1'b0;
      chk("max_valid", 32'(a_out_valid), 1);
      chk("max_acc",   32'(a_out_acc), 2040);
      chk("max_rdy",   32'(a_in_ready), 0);
`ifdef SUM_ACC_CNT_EN
      chk("max_cnt",   32'(a_out_cnt), 4);
`endif
      deliver_a();
      chk("max_dlv_valid", 32'(a_out_valid), 0);
      chk("max_dlv_acc",   32'(a_out_acc), 0);

      // Flush in IDLE ignored, then early close
      a_flush = 1'b1;
      step();
      a_flush = 1'b0;
      chk("idle_flush_valid", 32'(a_out_valid), 0);
      chk("idle_flush_rdy",   32'(a_in_ready), 1);
      send(9'd3, 1'b0);
      send(9'd5, 1'b1);
      chk("flush_valid", 32'(a_out_valid), 1);
      chk("flush_acc",   32'(a_out_acc), 8);
`ifdef SUM_ACC_CNT_EN
      chk("flush_cnt",   32'(a_out_cnt), 2);
`endif
      a_flush = 1'b1;
      step();
      a_flush = 1'b0;
      chk("hold_flush_acc", 32'(a_out_acc), 8);
      deliver_a();

      // Backpressure in HOLD
      send(9'd1, 1'b0); send(9'd2, 1'b0); send(9'd3, 1'b0); send(9'd4, 1'b0);
      a_in_valid = 1'b1;
      a_in_sum   = 9'd7;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_rdy",   32'(a_in_ready), 0);
         chk("bp_acc",   32'(a_out_acc), 10);
         chk("bp_valid", 32'(a_out_valid), 1);
      end
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
      chk("bp_dlv_valid", 32'(a_out_valid), 0);
      repeat (4) step();
      a_in_valid = 1'b0;
      chk("bp_next_valid", 32'(a_out_valid), 1);
      chk("bp_next_acc",   32'(a_out_acc), 28);
      deliver_a();

      // Flush in ACCUM with no accept
      send(9'd20, 1'b0);
      send(9'd30, 1'b0);
      a_flush = 1'b1;
      step();
      a_flush = 1'b0;
      chk("accflush_valid", 32'(a_out_valid), 1);
      chk("accflush_acc",   32'(a_out_acc), 50);
`ifdef SUM_ACC_CNT_EN
      chk("accflush_cnt",   32'(a_out_cnt), 2);
`endif
      deliver_a();

      // Reset mid-burst
      send(9'd100, 1'b0);
      send(9'd100, 1'b0);
      rst = 1'b1;
      #2;
      chk("midrst_valid", 32'(a_out_valid), 0);
      chk("midrst_acc",   32'(a_out_acc), 0);
      chk("midrst_rdy",   32'(a_in_ready), 0);
      rst = 1'b0;
      #1;
      repeat (4) send(9'd1, 1'b0);
      chk("postrst_valid", 32'(a_out_valid), 1);
      chk("postrst_acc",   32'(a_out_acc), 4);
      deliver_a();

      // COUNT=1: one result every two cycles
      b_in_valid  = 1'b1;
      b_in_sum    = 9'd9;
      b_out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("c1_valid", 32'(b_out_valid), (i % 2 == 0) ? 1 : 0);
         chk("c1_acc",   32'(b_out_acc),   (i % 2 == 0) ? 9 : 0);
`ifdef SUM_ACC_CNT_EN
         chk("c1_cnt",   32'(b_out_cnt),   (i % 2 == 0) ? 1 : 0);
`endif
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b0;
      step();

      // Random gaps inside bursts
      for (int b = 0; b < 4; b++) begin
         exp_sum = 0;
         for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) step();
            v = $urandom_range(0, 510);
            exp_sum += v;
            send(v[8:0], 1'b0);
         end
         repeat ($urandom_range(0, 2)) step();
         chk("gap_valid", 32'(a_out_valid), 1);
         chk("gap_acc",   32'(a_out_acc), exp_sum);
         deliver_a();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
